// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D cache to main-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Grants the I-cache or D-cache onto the shared memory port; all outputs registered.
// Build option ARB_ROUND_ROBIN_EN: alternate grants on ties instead of D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              d_req;
    logic              d_wins;

    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // On a tie, the side that was not served last goes next.
    function automatic logic pick_d(input logic i_rq, input logic d_rq, input logic last);
        return d_rq & (~i_rq | (last == GNT_I));
    endfunction

    assign d_wins = pick_d(i_read, d_req, last_grant_q);
`else
    assign d_wins = d_req;
`endif

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_wins) begin
                    state_d     = BUSY_D;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // A simultaneous read+write is illegal; the writeback wins.
                    mem_write_d = d_write;
                    mem_read_d  = d_read & ~d_write;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = GNT_D;
`endif
                end else if (i_read) begin
                    state_d    = BUSY_I;
                    mem_addr_d = i_addr;
                    mem_read_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = GNT_I;
`endif
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_rdata_d   = mem_rdata;
                    i_ready_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) d_rdata_d = mem_rdata;
                    d_ready_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= GNT_I;
`endif
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, priority, writeback, busy-hold, reset, zero-wait.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read, d_read, d_write, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_ready, d_ready, mem_read, mem_write;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad   = 0;
    logic rr;

    localparam logic [DW-1:0] LINE_A = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [DW-1:0] LINE_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [DW-1:0] LINE_C = 128'hCAFEF00D_0000_1111_2222_3333_4444_5555;
    localparam logic [DW-1:0] LINE_D = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
    localparam logic [DW-1:0] LINE_E = 128'h0000_0000_0000_0000_0000_0000_0000_00E1;
    localparam logic [DW-1:0] LINE_F = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    localparam logic [DW-1:0] WB     = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    localparam logic [DW-1:0] JUNK   = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait 'lat' cycles with the strobe up, then return the line; leaves us in the RESP cycle.
    task automatic mem_ack(input int lat, input logic [DW-1:0] data);
        for (int k = 0; k < lat; k++) tick();
        mem_ready = 1'b1;
        mem_rdata = data;
        tick();
        mem_ready = 1'b0;
        mem_rdata = JUNK;
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_i_rdata", i_rdata, 0);
        rst_n = 1'b1;
        tick();

        // I-only read, memory latency 3
        i_read = 1; i_addr = 28'h0000040;
        tick();
        chk("i_only_strobe", mem_read, 1);
        chk("i_only_addr", mem_addr, 28'h40);
        mem_ack(3, LINE_A);
        chk("i_only_ready", i_ready, 1);
        chk("i_only_rdata", i_rdata, LINE_A);
        chk("i_only_d_ready", d_ready, 0);
        chk("i_only_strobe_off", mem_read, 0);
        i_read = 0;
        tick();
        chk("i_only_ready_drop", i_ready, 0);

        // Tie: D first, then I
        i_read = 1; i_addr = 28'h40; d_read = 1; d_addr = 28'h80;
        tick();
        chk("tie_d_addr", mem_addr, 28'h80);
        chk("tie_d_strobe", mem_read, 1);
        mem_ack(1, LINE_B);
        chk("tie_d_ready", d_ready, 1);
        chk("tie_d_rdata", d_rdata, LINE_B);
        chk("tie_i_not_ready", i_ready, 0);
        d_read = 0;
        tick();
        chk("tie_resp_no_grant", mem_read, 0);
        tick();
        chk("tie_i_addr", mem_addr, 28'h40);
        mem_ack(0, LINE_C);
        chk("tie_i_ready", i_ready, 1);
        chk("tie_i_rdata", i_rdata, LINE_C);
        chk("tie_d_rdata_hold", d_rdata, LINE_B);
        i_read = 0;
        tick();

        // Second tie with D re-requesting: baseline picks D again, round-robin picks I
        i_read = 1; i_addr = 28'h44; d_read = 1; d_addr = 28'h90;
        tick();
        chk("tie2_first_d", mem_addr, 28'h90);
        mem_ack(0, LINE_D);
        chk("tie2_d_ready", d_ready, 1);
        d_addr = 28'hA0;
        tick();
        tick();
        chk("tie2_next_grant", mem_addr, rr ? 28'h44 : 28'hA0);
        mem_ack(0, LINE_E);
        if (rr) i_read = 0; else d_read = 0;
        tick();
        tick();
        chk("tie2_other_grant", mem_addr, rr ? 28'hA0 : 28'h44);
        mem_ack(0, LINE_F);
        i_read = 0; d_read = 0;
        tick();

        // Writeback, with an illegal simultaneous read that must be ignored
        d_write = 1; d_read = 1; d_addr = 28'h10; d_wdata = WB;
        tick();
        d_wdata = JUNK; d_addr = 28'h77;
        chk("wb_write", mem_write, 1);
        chk("wb_no_read", mem_read, 0);
        chk("wb_addr", mem_addr, 28'h10);
        tick(); tick();
        chk("wb_wdata_stable", mem_wdata, WB);
        chk("wb_write_held", mem_write, 1);
        mem_ack(0, JUNK);
        chk("wb_d_ready", d_ready, 1);
        chk("wb_write_off", mem_write, 0);
        chk("wb_d_rdata_unchanged", d_rdata, rr ? LINE_F : LINE_E);
        d_write = 0; d_read = 0;
        tick();
        chk("wb_ready_drop", d_ready, 0);

        // Request changes while BUSY_I are ignored
        i_read = 1; i_addr = 28'h20;
        tick();
        i_addr = 28'h99; d_read = 1; d_addr = 28'h30;
        tick();
        chk("busy_addr_hold", mem_addr, 28'h20);
        chk("busy_strobe_hold", mem_read, 1);
        mem_ack(1, LINE_E);
        chk("busy_i_ready", i_ready, 1);
        chk("busy_i_rdata", i_rdata, LINE_E);
        chk("busy_no_d_ready", d_ready, 0);
        i_read = 0;
        tick();
        chk("busy_idle_no_strobe", mem_read, 0);
        tick();
        chk("busy_d_granted", mem_addr, 28'h30);
        mem_ack(0, LINE_A);
        chk("busy_d_rdata", d_rdata, LINE_A);
        d_read = 0;
        tick();

        // Reset during BUSY_D with a write in flight
        d_write = 1; d_addr = 28'h50; d_wdata = WB;
        tick();
        chk("rstmid_write_up", mem_write, 1);
        rst_n = 0;
        tick();
        chk("rstmid_write", mem_write, 0);
        chk("rstmid_addr", mem_addr, 0);
        chk("rstmid_wdata", mem_wdata, 0);
        chk("rstmid_d_rdata", d_rdata, 0);
        d_write = 0; rst_n = 1; mem_ready = 1; mem_rdata = JUNK;
        tick();
        mem_ready = 0;
        chk("stray_i_ready", i_ready, 0);
        chk("stray_d_ready", d_ready, 0);
        tick();
        chk("stray_d_ready2", d_ready, 0);
        chk("stray_d_rdata", d_rdata, 0);

        // Back-to-back zero-wait I reads
        i_read = 1; i_addr = 28'h60;
        tick();
        chk("b2b_strobe1", mem_read, 1);
        mem_ack(0, LINE_B);
        chk("b2b_ready1", i_ready, 1);
        chk("b2b_rdata1", i_rdata, LINE_B);
        i_addr = 28'h61;
        tick();
        chk("b2b_gap_ready", i_ready, 0);
        chk("b2b_gap_strobe", mem_read, 0);
        tick();
        chk("b2b_strobe2", mem_read, 1);
        chk("b2b_addr2", mem_addr, 28'h61);
        chk("b2b_no_ready", i_ready, 0);
        mem_ack(0, LINE_C);
        chk("b2b_ready2", i_ready, 1);
        chk("b2b_rdata2", i_rdata, LINE_C);
        i_read = 0;
        tick();
        chk("b2b_ready2_drop", i_ready, 0);
        tick();
        chk("b2b_quiet", i_ready, 0);
        chk("b2b_quiet_strobe", mem_read, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
